// File: rtl/xburst_native.sv
// Burst-to-native memory adapter: splits merged write/read bursts into single-beat
// native transfers with round-robin channel arbitration and atomic bursts.
module xburst_native #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [ADDR_W-1:0]   w_addr_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  input  logic [LEN_W-1:0]    w_len_i,
  output logic                w_last_o,
  input  logic                r_valid_i,
  output logic                r_ready_o,
  input  logic [ADDR_W-1:0]   r_addr_i,
  output logic [DATA_W-1:0]   r_data_o,
  input  logic [LEN_W-1:0]    r_len_i,
  output logic                r_last_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(STRB_W);
  localparam logic [LEN_W:0] ONE = (LEN_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W:0]      beat_q, beat_d;
  logic [LEN_W:0]      issue_q, issue_d;
  logic [LEN_W:0]      ret_q, ret_d;
  logic                prio_q, prio_d;   // 1: write wins a contended grant

  logic [LEN_W:0]      len_ext;
  logic                rd_issue;
  logic                rd_return;

  assign len_ext = {1'b0, len_q};

  // Native-port and channel outputs are combinational pass-throughs of the current state.
  always_comb begin
    w_ready_o   = 1'b0;
    w_last_o    = 1'b0;
    r_ready_o   = 1'b0;
    r_data_o    = '0;
    r_last_o    = 1'b0;
    mem_valid_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    rd_issue    = 1'b0;
    rd_return   = 1'b0;
    case (state_q)
      WRITE: begin
        mem_valid_o = w_valid_i;
        mem_addr_o  = addr_q;
        mem_wdata_o = w_data_i;
        mem_wstrb_o = w_strb_i;
        w_ready_o   = mem_ready_i;
        w_last_o    = (beat_q == len_ext);
      end
      READ: begin
        mem_valid_o = (issue_q <= len_ext);
        mem_addr_o  = addr_q;
        rd_issue    = mem_valid_o && mem_ready_i;
        rd_return   = mem_rvalid_i && (ret_q <= len_ext);
        r_ready_o   = rd_return;
        r_data_o    = rd_return ? mem_rdata_i : '0;
        r_last_o    = rd_return && (ret_q == len_ext);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    issue_d = issue_q;
    ret_d   = ret_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (w_valid_i && (!r_valid_i || prio_q)) begin
          state_d = WRITE;
          addr_d  = w_addr_i;
          len_d   = w_len_i;
          beat_d  = '0;
          issue_d = '0;
          ret_d   = '0;
          prio_d  = 1'b0;
        end else if (r_valid_i) begin
          state_d = READ;
          addr_d  = r_addr_i;
          len_d   = r_len_i;
          beat_d  = '0;
          issue_d = '0;
          ret_d   = '0;
          prio_d  = 1'b1;
        end
      end
      WRITE: begin
        if (w_valid_i && mem_ready_i) begin
          beat_d = beat_q + ONE;
          addr_d = addr_q + STRIDE;
          if (beat_q == len_ext) state_d = IDLE;
        end
      end
      READ: begin
        // Issue and return counters advance independently; returns may overlap issues.
        if (rd_issue) begin
          issue_d = issue_q + ONE;
          addr_d  = addr_q + STRIDE;
        end
        if (rd_return) begin
          ret_d = ret_q + ONE;
          if (ret_q == len_ext) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      issue_q <= '0;
      ret_q   <= '0;
      prio_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_xburst_native.sv
// Directed self-checking bench for xburst_native; a second 8-bit-address instance
// runs in lockstep to observe address wrap.
module tb_xburst_native;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        w_valid, r_valid, mem_ready, mem_rvalid;
  logic [31:0] w_addr, r_addr, w_data, mem_rdata;
  logic [3:0]  w_strb;
  logic [7:0]  w_len, r_len;

  logic        w_ready_o, w_last_o, r_ready_o, r_last_o, mem_valid_o;
  logic [31:0] r_data_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;

  logic        w_ready8, w_last8, r_ready8, r_last8, mem_valid8;
  logic [31:0] r_data8, mem_wdata8;
  logic [7:0]  mem_addr8;
  logic [3:0]  mem_wstrb8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  xburst_native dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .w_valid_i(w_valid), .w_ready_o(w_ready_o), .w_addr_i(w_addr), .w_data_i(w_data),
    .w_strb_i(w_strb), .w_len_i(w_len), .w_last_o(w_last_o),
    .r_valid_i(r_valid), .r_ready_o(r_ready_o), .r_addr_i(r_addr), .r_data_o(r_data_o),
    .r_len_i(r_len), .r_last_o(r_last_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  xburst_native #(.ADDR_W(8)) dut8 (
    .clk_i(clk_i), .rst_i(rst_i),
    .w_valid_i(w_valid), .w_ready_o(w_ready8), .w_addr_i(w_addr[7:0]), .w_data_i(w_data),
    .w_strb_i(w_strb), .w_len_i(w_len), .w_last_o(w_last8),
    .r_valid_i(r_valid), .r_ready_o(r_ready8), .r_addr_i(r_addr[7:0]), .r_data_o(r_data8),
    .r_len_i(r_len), .r_last_o(r_last8),
    .mem_valid_o(mem_valid8), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr8),
    .mem_wdata_o(mem_wdata8), .mem_wstrb_o(mem_wstrb8),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    w_valid = 1'b1; r_valid = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b1;
    w_addr = 32'h10; r_addr = 32'h20; w_data = 32'h1234_5678; w_strb = 4'hF;
    w_len = 8'd0; r_len = 8'd0; mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      total_cnt++;
      if ({mem_valid_o, w_ready_o, w_last_o, r_ready_o, r_last_o} !== 5'b0 ||
          mem_addr_o !== 32'h0 || mem_wstrb_o !== 4'h0 || mem_wdata_o !== 32'h0 || r_data_o !== 32'h0)
        $display("FAIL reset_outputs cycle %0d: got valid=%b wr=%b wl=%b rr=%b rl=%b addr=%h required all 0",
                 i, mem_valid_o, w_ready_o, w_last_o, r_ready_o, r_last_o, mem_addr_o);
      else pass_cnt++;
    end
    w_valid = 1'b0; r_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    tick();
    rst_i = 1'b1;
    $display("reset: outputs idle while held");
  endtask

  task automatic test_write_burst();
    tick();
    w_valid = 1'b1; w_addr = 32'h100; w_len = 8'd3; mem_ready = 1'b1; #1;
    total_cnt++;
    if (mem_valid_o !== 1'b0) $display("FAIL wb_grant_idle: got mem_valid=%b required 0", mem_valid_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      w_data = 32'hA000_0000 + 32'(i); w_strb = 4'(i + 1); w_addr = 32'hDEAD_0000; #1;
      total_cnt++;
      if ({mem_valid_o, w_ready_o, w_last_o} !== {1'b1, 1'b1, (i == 3)})
        $display("FAIL wb_ctrl beat %0d: got valid/ready/last=%b%b%b required 11%b",
                 i, mem_valid_o, w_ready_o, w_last_o, (i == 3));
      else pass_cnt++;
      total_cnt++;
      if (mem_addr_o !== 32'h100 + 32'(4 * i))
        $display("FAIL wb_addr beat %0d: got %h required %h", i, mem_addr_o, 32'h100 + 32'(4 * i));
      else pass_cnt++;
      total_cnt++;
      if (mem_wdata_o !== 32'hA000_0000 + 32'(i) || mem_wstrb_o !== 4'(i + 1))
        $display("FAIL wb_data beat %0d: got %h/%h required %h/%h",
                 i, mem_wdata_o, mem_wstrb_o, 32'hA000_0000 + 32'(i), 4'(i + 1));
      else pass_cnt++;
      $display("write beat %0d addr=%h data=%h strb=%h last=%b", i, mem_addr_o, mem_wdata_o, mem_wstrb_o, w_last_o);
    end
    tick();
    w_valid = 1'b0; #1;
    total_cnt++;
    if ({mem_valid_o, w_ready_o, w_last_o} !== 3'b000 || mem_addr_o !== 32'h0)
      $display("FAIL wb_idle_after: got valid/ready/last=%b%b%b addr=%h required 000/0",
               mem_valid_o, w_ready_o, w_last_o, mem_addr_o);
    else pass_cnt++;
  endtask

  task automatic test_write_stall();
    int accepted;
    accepted = 0;
    tick();
    w_valid = 1'b1; w_addr = 32'h200; w_len = 8'd1; mem_ready = 1'b0; w_data = 32'h55; w_strb = 4'h3;
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      total_cnt++;
      if ({mem_valid_o, w_ready_o} !== 2'b10 || mem_addr_o !== 32'h200)
        $display("FAIL ws_stall cycle %0d: got valid/ready=%b%b addr=%h required 10/00000200",
                 k, mem_valid_o, w_ready_o, mem_addr_o);
      else pass_cnt++;
      if (w_valid && w_ready_o) accepted++;
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      mem_ready = 1'b1; #1;
      total_cnt++;
      if ({w_ready_o, w_last_o} !== {1'b1, (i == 1)} || mem_addr_o !== 32'h200 + 32'(4 * i))
        $display("FAIL ws_resume beat %0d: got ready/last=%b%b addr=%h required 1%b/%h",
                 i, w_ready_o, w_last_o, mem_addr_o, (i == 1), 32'h200 + 32'(4 * i));
      else pass_cnt++;
      if (w_valid && w_ready_o) accepted++;
      $display("stalled write beat %0d addr=%h", i, mem_addr_o);
    end
    tick();
    w_valid = 1'b0; #1;
    total_cnt++;
    if (w_ready_o !== 1'b0 || mem_valid_o !== 1'b0)
      $display("FAIL ws_idle_ready: got w_ready=%b mem_valid=%b required 0/0", w_ready_o, mem_valid_o);
    else pass_cnt++;
    total_cnt++;
    if (accepted !== 2) $display("FAIL ws_accepted: got %0d beats required 2", accepted);
    else pass_cnt++;
  endtask

  task automatic test_read_burst();
    tick();
    r_valid = 1'b1; r_addr = 32'h40; r_len = 8'd2; mem_ready = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      r_valid = 1'b0; r_addr = 32'hBEEF_0000; #1;
      total_cnt++;
      if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h40 + 32'(4 * i) || mem_wstrb_o !== 4'h0 || mem_wdata_o !== 32'h0)
        $display("FAIL rd_issue %0d: got valid=%b addr=%h strb=%h required 1/%h/0",
                 i, mem_valid_o, mem_addr_o, mem_wstrb_o, 32'h40 + 32'(4 * i));
      else pass_cnt++;
      $display("read issue %0d addr=%h", i, mem_addr_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hD000_0000 + 32'(i); #1;
      total_cnt++;
      if (mem_valid_o !== 1'b0) $display("FAIL rd_issue_done %0d: got mem_valid=%b required 0", i, mem_valid_o);
      else pass_cnt++;
      total_cnt++;
      if ({r_ready_o, r_last_o} !== {1'b1, (i == 2)} || r_data_o !== 32'hD000_0000 + 32'(i))
        $display("FAIL rd_return %0d: got ready/last=%b%b data=%h required 1%b/%h",
                 i, r_ready_o, r_last_o, r_data_o, (i == 2), 32'hD000_0000 + 32'(i));
      else pass_cnt++;
      $display("read return %0d data=%h last=%b", i, r_data_o, r_last_o);
    end
    tick();
    mem_rdata = 32'h7777_7777; #1;
    total_cnt++;
    if (r_ready_o !== 1'b0 || r_data_o !== 32'h0 || mem_valid_o !== 1'b0)
      $display("FAIL rd_stray_rvalid: got r_ready=%b data=%h valid=%b required 0/0/0",
               r_ready_o, r_data_o, mem_valid_o);
    else pass_cnt++;
    mem_rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    tick();
    rst_i = 1'b0;
    w_valid = 1'b1; r_valid = 1'b1; w_addr = 32'h300; r_addr = 32'h400;
    w_len = 8'd0; r_len = 8'd0; w_strb = 4'hF; mem_ready = 1'b1;
    tick();
    rst_i = 1'b1;
    for (int g = 0; g < 4; g++) begin
      mem_rvalid = 1'b0; #1;
      total_cnt++;
      if (mem_valid_o !== 1'b0) $display("FAIL b2b_gap %0d: got mem_valid=%b required 0", g, mem_valid_o);
      else pass_cnt++;
      tick(); #1;
      total_cnt++;
      if ((g % 2) == 0) begin
        if (mem_valid_o !== 1'b1 || mem_wstrb_o !== 4'hF || w_last_o !== 1'b1 || mem_addr_o !== 32'h300)
          $display("FAIL b2b_grant %0d: got valid=%b strb=%h addr=%h required write 1/f/00000300",
                   g, mem_valid_o, mem_wstrb_o, mem_addr_o);
        else pass_cnt++;
        $display("grant %0d: write addr=%h", g, mem_addr_o);
      end else begin
        if (mem_valid_o !== 1'b1 || mem_wstrb_o !== 4'h0 || w_ready_o !== 1'b0 || mem_addr_o !== 32'h400)
          $display("FAIL b2b_grant %0d: got valid=%b strb=%h addr=%h required read 1/0/00000400",
                   g, mem_valid_o, mem_wstrb_o, mem_addr_o);
        else pass_cnt++;
        $display("grant %0d: read addr=%h", g, mem_addr_o);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h4444_0000 + 32'(g); #1;
        total_cnt++;
        if ({r_ready_o, r_last_o} !== 2'b11)
          $display("FAIL b2b_return %0d: got ready/last=%b%b required 11", g, r_ready_o, r_last_o);
        else pass_cnt++;
      end
      tick();
    end
    w_valid = 1'b0; r_valid = 1'b0; mem_rvalid = 1'b0; #1;
    total_cnt++;
    if (mem_valid_o !== 1'b0) $display("FAIL b2b_end: got mem_valid=%b required 0", mem_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_addr_wrap();
    tick();
    w_valid = 1'b1; w_addr = 32'hFC; w_len = 8'd1; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      total_cnt++;
      if (mem_addr8 !== ((i == 0) ? 8'hFC : 8'h00) || mem_valid8 !== 1'b1 || w_last8 !== (i == 1))
        $display("FAIL wrap8 beat %0d: got addr=%h valid=%b last=%b required %h/1/%b",
                 i, mem_addr8, mem_valid8, w_last8, (i == 0) ? 8'hFC : 8'h00, (i == 1));
      else pass_cnt++;
      total_cnt++;
      if (mem_addr_o !== 32'hFC + 32'(4 * i))
        $display("FAIL wrap32 beat %0d: got addr=%h required %h", i, mem_addr_o, 32'hFC + 32'(4 * i));
      else pass_cnt++;
      $display("wrap beat %0d addr8=%h addr32=%h", i, mem_addr8, mem_addr_o);
    end
    tick();
    w_valid = 1'b0;
  endtask

  task automatic test_max_len();
    int lasts;
    lasts = 0;
    tick();
    w_valid = 1'b1; w_addr = 32'h0; w_len = 8'hFF; mem_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick(); #1;
      if (w_last_o === 1'b1) lasts++;
      if (i == 255) begin
        total_cnt++;
        if (w_last_o !== 1'b1 || mem_addr_o !== 32'h3FC || mem_valid_o !== 1'b1)
          $display("FAIL maxlen_final: got last=%b addr=%h valid=%b required 1/000003fc/1",
                   w_last_o, mem_addr_o, mem_valid_o);
        else pass_cnt++;
      end
    end
    $display("max-length write: 256 beats, last flags seen=%0d", lasts);
    tick();
    w_valid = 1'b0; #1;
    total_cnt++;
    if (lasts !== 1 || mem_valid_o !== 1'b0)
      $display("FAIL maxlen_count: got lasts=%0d valid=%b required 1/0", lasts, mem_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    tick();
    r_valid = 1'b1; r_addr = 32'h80; r_len = 8'd3; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      r_valid = 1'b0; #1;
      total_cnt++;
      if (mem_addr_o !== 32'h80 + 32'(4 * i))
        $display("FAIL rst_rd_issue %0d: got addr=%h required %h", i, mem_addr_o, 32'h80 + 32'(4 * i));
      else pass_cnt++;
    end
    tick();
    rst_i = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      rst_i = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h9999_0000 + 32'(i); #1;
      total_cnt++;
      if ({mem_valid_o, w_ready_o, w_last_o, r_ready_o, r_last_o} !== 5'b0 ||
          r_data_o !== 32'h0 || mem_addr_o !== 32'h0)
        $display("FAIL rst_rd_late %0d: got valid=%b rr=%b rl=%b data=%h addr=%h required all 0",
                 i, mem_valid_o, r_ready_o, r_last_o, r_data_o, mem_addr_o);
      else pass_cnt++;
      $display("late return %0d after reset: r_ready=%b", i, r_ready_o);
    end
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_write_stall();
    test_read_burst();
    test_back_to_back();
    test_addr_wrap();
    test_max_len();
    test_reset_mid_read();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
